led_blink_coder: RTL and testbench

//  Downstream LED output stage for the iCE40 board designs. Takes blink codes

---
 rtl/led_pkg.sv | 16 +
 rtl/led_tick_prescaler.sv | 31 +++
 rtl/led_blink_coder.sv | 143 ++++++++++++++
 tb/tb_led_blink_coder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED blink-code logic.
// Holds the FSM state encoding and the prescaler divide-ratio function.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } led_state_t;

  function automatic int cyc_per_tick(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Divides the clock down to a one-cycle tick strobe every CYC_PER_TICK cycles.
// A synchronous clear restarts the count, so the first tick after clear is a full one.
module led_tick_prescaler #(
  parameter int CYC_PER_TICK = 12000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (CYC_PER_TICK > 1) ? $clog2(CYC_PER_TICK) : 1;
  localparam logic [W-1:0] LAST = W'(CYC_PER_TICK - 1);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Left ungated by clr: the FSM derives clr from this strobe.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_blink_coder.sv
// LED output stage: shows each accepted blink code N as N PWM-dimmed pulses
// followed by a dark gap, optionally replaying the code until replaced.
module led_blink_coder
  import led_pkg::*;
#(
  parameter int CLK_HZ    = 12_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int ON_TICKS  = 200,
  parameter int OFF_TICKS = 200,
  parameter int GAP_TICKS = 1000,
  parameter int PWM_BITS  = 8
) (
  input  logic                clk12mhz,
  input  logic                rst_n,
  input  logic                code_valid,
  output logic                code_ready,
  input  logic [3:0]          code_data,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                repeat_en,
  output logic                busy,
  output logic                ledRed
);

  localparam int CYC    = cyc_per_tick(CLK_HZ, TICK_HZ);
  localparam int PH_MAX = (ON_TICKS > OFF_TICKS)
                          ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                          : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  led_state_t          state, state_nxt;
  logic [PH_W-1:0]     phase_cnt, phase_last;
  logic [3:0]          remaining, code_lat;
  logic [PWM_BITS-1:0] bright_lat, pwm_cnt;
  logic                tick, expire, xfer, clr;
  logic                load, reload, dec;

  assign code_ready = (state == ST_IDLE) || (state == ST_GAP);
  assign xfer       = code_valid && code_ready;
  assign busy       = (state != ST_IDLE);

  led_tick_prescaler #(
    .CYC_PER_TICK(CYC)
  ) u_prescaler (
    .clk  (clk12mhz),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    phase_last = '0;
    case (state)
      ST_ON:   phase_last = PH_W'(ON_TICKS - 1);
      ST_OFF:  phase_last = PH_W'(OFF_TICKS - 1);
      ST_GAP:  phase_last = PH_W'(GAP_TICKS - 1);
      default: phase_last = '0;
    endcase
  end

  assign expire = tick && (phase_cnt == phase_last);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    reload    = 1'b0;
    dec       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (xfer && (code_data != 4'd0)) begin
          state_nxt = ST_ON;
          load      = 1'b1;
        end
      end
      ST_ON: begin
        if (expire) begin
          state_nxt = ST_OFF;
          dec       = 1'b1;
        end
      end
      ST_OFF: begin
        if (expire) begin
          state_nxt = (remaining == 4'd0) ? ST_GAP : ST_ON;
        end
      end
      ST_GAP: begin
        // A new code cuts the gap short; otherwise the gap runs to expiry.
        if (xfer) begin
          if (code_data != 4'd0) begin
            state_nxt = ST_ON;
            load      = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (expire) begin
          if (repeat_en) begin
            state_nxt = ST_ON;
            reload    = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Timing restarts on every state entry and is held cleared while idle.
  assign clr = (state_nxt != state) || (state == ST_IDLE);

  always_ff @(posedge clk12mhz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      remaining <= 4'd0;
      code_lat  <= 4'd0;
      bright_lat <= '0;
      pwm_cnt   <= '0;
      ledRed    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pwm_cnt <= pwm_cnt + 1'b1;
      ledRed  <= (state == ST_ON) && (pwm_cnt < bright_lat);

      if (clr) begin
        phase_cnt <= '0;
      end else if (tick) begin
        phase_cnt <= phase_cnt + 1'b1;
      end

      if (load) begin
        remaining  <= code_data;
        code_lat   <= code_data;
        bright_lat <= brightness;
      end else if (reload) begin
        remaining <= code_lat;
      end else if (dec) begin
        remaining <= remaining - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_led_blink_coder.sv
// Directed bench for led_blink_coder at 10 cycles/tick, ON=2, OFF=1, GAP=3 ticks,
// so one pulse slot is 20 lit + 10 dark cycles and the gap is 30 cycles.
module tb_led_blink_coder;

  logic       clk12mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic       code_valid = 1'b0;
  logic [3:0] code_data = 4'd0;
  logic [3:0] brightness = 4'd0;
  logic       repeat_en = 1'b0;
  logic       code_ready;
  logic       busy;
  logic       ledRed;

  int n_total = 0;
  int n_bad = 0;

  logic led_tr  [0:255];
  logic busy_tr [0:255];
  logic rdy_tr  [0:255];
  bit   win     [0:255];

  led_blink_coder #(
    .CLK_HZ   (1000),
    .TICK_HZ  (100),
    .ON_TICKS (2),
    .OFF_TICKS(1),
    .GAP_TICKS(3),
    .PWM_BITS (4)
  ) dut (
    .clk12mhz  (clk12mhz),
    .rst_n     (rst_n),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .code_data (code_data),
    .brightness(brightness),
    .repeat_en (repeat_en),
    .busy      (busy),
    .ledRed    (ledRed)
  );

  always #5 clk12mhz = ~clk12mhz;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Sample i is taken on the falling edge after rising edge k+i (k = transfer edge).
  task automatic capture(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk12mhz);
      led_tr[start+i]  = ledRed;
      busy_tr[start+i] = busy;
      rdy_tr[start+i]  = code_ready;
    end
  endtask

  task automatic send(input logic [3:0] c, input logic [3:0] b, input string tag);
    @(negedge clk12mhz);
    code_valid = 1'b1;
    code_data  = c;
    brightness = b;
    #1;
    check({tag, "_ready"}, int'(code_ready), 1);
    @(posedge clk12mhz);
    #1;
    code_valid = 1'b0;
    code_data  = 4'd0;
  endtask

  task automatic clear_win();
    for (int i = 0; i < 256; i++) win[i] = 1'b0;
  endtask

  // ON entered at sample s lights samples s+1..s+20; any 16 of them hold each PWM value once.
  task automatic win_check(input string tag, input int s, input int bright);
    int cnt;
    cnt = 0;
    for (int i = s + 1; i <= s + 16; i++) cnt += int'(led_tr[i]);
    for (int i = s + 1; i <= s + 20; i++) win[i] = 1'b1;
    check(tag, cnt, bright);
  endtask

  task automatic outside_check(input string tag, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) if (led_tr[i] && !win[i]) cnt++;
    check(tag, cnt, 0);
  endtask

  task automatic busy_check(input string tag, input int n, input int len);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) if (busy_tr[i] != (i < len)) errs++;
    check(tag, errs, 0);
  endtask

  initial begin
    int idx;

    repeat (3) @(negedge clk12mhz);
    check("rst_led", int'(ledRed), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(code_ready), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk12mhz);

    // Code 3, full brightness, single shot: 3*(20+10)+30 = 120 busy cycles.
    clear_win();
    repeat_en = 1'b0;
    send(4'd3, 4'd15, "t1");
    capture(0, 130);
    win_check("t1_p0", 0, 15);
    win_check("t1_p1", 30, 15);
    win_check("t1_p2", 60, 15);
    outside_check("t1_dark", 130);
    busy_check("t1_busy", 130, 120);
    check("t1_ready_on", int'(rdy_tr[5]), 0);
    check("t1_ready_gap", int'(rdy_tr[100]), 1);
    check("t1_ready_idle", int'(rdy_tr[125]), 1);

    // Code 2 repeating: rounds of 90 cycles; replace it with code 1 mid second gap.
    clear_win();
    repeat_en = 1'b1;
    send(4'd2, 4'd15, "t2");
    capture(0, 160);
    win_check("t2_r0p0", 0, 15);
    win_check("t2_r0p1", 30, 15);
    win_check("t2_r1p0", 90, 15);
    win_check("t2_r1p1", 120, 15);
    outside_check("t2_dark", 160);
    busy_check("t2_busy", 160, 1000);
    check("t2_ready_gap", int'(rdy_tr[70]), 1);

    clear_win();
    send(4'd1, 4'd15, "t2b");
    capture(0, 80);
    repeat_en = 1'b0;
    capture(80, 50);
    win_check("t2b_r0", 0, 15);
    win_check("t2b_r1", 60, 15);
    outside_check("t2b_dark", 130);
    busy_check("t2b_busy", 130, 120);

    // Code 0 from idle: accepted, nothing happens.
    clear_win();
    send(4'd0, 4'd15, "t3");
    capture(0, 20);
    busy_check("t3_busy", 20, 0);
    outside_check("t3_dark", 20);
    check("t3_ready", int'(rdy_tr[19]), 1);

    // Brightness 0: dark LED, timing unchanged (20+10+30).
    clear_win();
    send(4'd1, 4'd0, "t4");
    capture(0, 70);
    busy_check("t4_busy", 70, 60);
    outside_check("t4_dark", 70);

    // Asynchronous reset while lit.
    send(4'd2, 4'd15, "t5");
    idx = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk12mhz);
      if (ledRed) begin
        idx = i;
        break;
      end
    end
    check("t5_lit_seen", int'(idx >= 0), 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_led_async", int'(ledRed), 0);
    check("t5_busy_async", int'(busy), 0);
    check("t5_ready_async", int'(code_ready), 1);
    @(negedge clk12mhz);
    rst_n = 1'b1;
    clear_win();
    capture(0, 60);
    outside_check("t5_dark", 60);
    busy_check("t5_busy", 60, 0);
    check("t5_ready", int'(rdy_tr[59]), 1);

    // Valid held during ON/OFF: transfer waits for the first GAP cycle (sample 30).
    send(4'd1, 4'd15, "t6");
    code_valid = 1'b1;
    code_data  = 4'd2;
    brightness = 4'd15;
    idx = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk12mhz);
      if (code_ready) begin
        idx = i;
        break;
      end
    end
    check("t6_wait", idx, 30);
    @(posedge clk12mhz);
    #1;
    code_valid = 1'b0;
    code_data  = 4'd0;
    clear_win();
    capture(0, 100);
    win_check("t6_p0", 0, 15);
    win_check("t6_p1", 30, 15);
    outside_check("t6_dark", 100);
    busy_check("t6_busy", 100, 90);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
